// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B position decoder. Each asynchronous input is
// synchronised and glitch-filtered, then the filtered {A,B} pair is decoded
// into up/down steps that drive a WIDTH-bit modulo position count.
// Optional feature macro: QDEC_INDEX_CLR_EN -- when defined, a filtered 0->1
// edge on the index input qz clears the count (a coinciding load still wins).

// Per-input front end: synchroniser chain followed by a run-length filter.
module quad_decoder_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic synced,
  output logic filt,
  output logic filt_next
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] RUN_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          run_r;
  logic                   filt_r;
  logic [CW-1:0]          run_next_s;
  logic                   filt_next_s;

  // Filter decision: adopt the synced level once it has differed for FILT_LEN samples.
  always_comb begin
    run_next_s  = {CW{1'b0}};
    filt_next_s = filt_r;
    if (sync_r[SYNC_STAGES-1] == filt_r) begin
      run_next_s = {CW{1'b0}};
    end else if (run_r + RUN_ONE == RUN_LAST) begin
      run_next_s  = {CW{1'b0}};
      filt_next_s = sync_r[SYNC_STAGES-1];
    end else begin
      run_next_s = run_r + RUN_ONE;
    end
  end

  // Synchroniser shift and filter state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      run_r  <= {CW{1'b0}};
      filt_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      run_r  <= run_next_s;
      filt_r <= filt_next_s;
    end
  end

  assign synced    = sync_r[SYNC_STAGES-1];
  assign filt      = filt_r;
  assign filt_next = filt_next_s;
endmodule

module quad_decoder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             qz,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out,
  output logic             step,
  output logic             dir,
  output logic             err
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]    RUN_ONE   = CW'(32'd1);
  localparam logic [CW-1:0]    RUN_LAST  = CW'(FILT_LEN);
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(32'd1);

  // Position of an {A,B} pair within one quadrature cycle (A leads B going up).
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_phase = 2'd0;
      2'b10:   quad_phase = 2'd1;
      2'b11:   quad_phase = 2'd2;
      2'b01:   quad_phase = 2'd3;
      default: quad_phase = 2'd0;
    endcase
  endfunction

  logic a_sync_s, a_filt_s, a_next_s;
  logic b_sync_s, b_filt_s, b_next_s;
  logic z_rise_s;

  quad_decoder_chan #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_chan_a (
    .clk(clk), .rst(rst), .din(qa),
    .synced(a_sync_s), .filt(a_filt_s), .filt_next(a_next_s)
  );

  quad_decoder_chan #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_chan_b (
    .clk(clk), .rst(rst), .din(qb),
    .synced(b_sync_s), .filt(b_filt_s), .filt_next(b_next_s)
  );

`ifdef QDEC_INDEX_CLR_EN
  logic z_sync_unused_s, z_filt_s, z_next_s;

  quad_decoder_chan #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_chan_z (
    .clk(clk), .rst(rst), .din(qz),
    .synced(z_sync_unused_s), .filt(z_filt_s), .filt_next(z_next_s)
  );

  assign z_rise_s = z_next_s & ~z_filt_s;
`else
  logic qz_unused_s;

  assign qz_unused_s = qz;
  assign z_rise_s    = 1'b0;
`endif

  logic [WIDTH-1:0] count_r;
  logic             step_r, dir_r, err_r, primed_r;
  logic [CW-1:0]    prime_cnt_r;

  logic [1:0]    cur_ab_s, next_ab_s, delta_s;
  logic          up_s, down_s, bad_s;
  logic          primed_next_s;
  logic [CW-1:0] prime_cnt_next_s;

  // Decode the filtered {A,B} change on this edge into up, down or illegal.
  always_comb begin
    cur_ab_s  = {a_filt_s, b_filt_s};
    next_ab_s = {a_next_s, b_next_s};
    delta_s   = quad_phase(next_ab_s) - quad_phase(cur_ab_s);
    up_s      = 1'b0;
    down_s    = 1'b0;
    bad_s     = 1'b0;
    if (primed_r && (next_ab_s != cur_ab_s)) begin
      case (delta_s)
        2'd1:    up_s   = 1'b1;
        2'd3:    down_s = 1'b1;
        2'd2:    bad_s  = 1'b1;
        default: bad_s  = 1'b0;
      endcase
    end else begin
      up_s = 1'b0;
    end
  end

  // Priming: first filtered update is only captured, or a settled 00 input arms decoding.
  always_comb begin
    primed_next_s    = primed_r;
    prime_cnt_next_s = {CW{1'b0}};
    if (primed_r) begin
      primed_next_s = 1'b1;
    end else if (next_ab_s != cur_ab_s) begin
      primed_next_s = 1'b1;
    end else if ({a_sync_s, b_sync_s} == 2'b00) begin
      if (prime_cnt_r + RUN_ONE == RUN_LAST) begin
        primed_next_s = 1'b1;
      end else begin
        prime_cnt_next_s = prime_cnt_r + RUN_ONE;
      end
    end else begin
      prime_cnt_next_s = {CW{1'b0}};
    end
  end

  // Registered count, event pulses and direction; load beats index clear beats step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r     <= {WIDTH{1'b0}};
      step_r      <= 1'b0;
      dir_r       <= 1'b0;
      err_r       <= 1'b0;
      primed_r    <= 1'b0;
      prime_cnt_r <= {CW{1'b0}};
    end else begin
      primed_r    <= primed_next_s;
      prime_cnt_r <= prime_cnt_next_s;
      step_r      <= up_s | down_s;
      err_r       <= bad_s;
      if (up_s) begin
        dir_r <= 1'b1;
      end else if (down_s) begin
        dir_r <= 1'b0;
      end else begin
        dir_r <= dir_r;
      end
      if (load) begin
        count_r <= data;
      end else if (z_rise_s) begin
        count_r <= {WIDTH{1'b0}};
      end else if (up_s) begin
        count_r <= count_r + COUNT_ONE;
      end else if (down_s) begin
        count_r <= count_r - COUNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign data_out = count_r;
  assign step     = step_r;
  assign dir      = dir_r;
  assign err      = err_r;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed test-plan sequences plus randomized A/B/load/reset
// stimulus, every cycle compared against a behavioural reference model.
module tb_quad_decoder;
  localparam int WIDTH = 16;
  localparam int SS    = 2;
  localparam int FL    = 3;

  logic             clk = 1'b0;
  logic             rst, qa, qb, qz, load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_out;
  logic             step, dir, err;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .qz(qz), .load(load), .data(data),
    .data_out(data_out), .step(step), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nsteps, nerrs, lat;

  // Reference model state.
  int m_count;
  bit m_fa, m_fb, m_fz, m_primed, m_dir, m_step, m_err;
  bit sq_a[$], sq_b[$], sq_z[$];
  bit win_a[$], win_b[$], win_z[$];
  int pos_of[4] = '{0, 3, 1, 2};   // index {A,B}: 00,01,10,11

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit full_of(input bit q[$], input bit v);
    if (q.size() != FL) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit sa, sb, sz, na, nb, nz, chg, up, dn, zrise;
    int d;
    if (!rst) begin
      sq_a = {}; sq_b = {}; sq_z = {};
      for (int i = 0; i < SS; i++) begin
        sq_a.push_back(1'b0); sq_b.push_back(1'b0); sq_z.push_back(1'b0);
      end
      win_a = {}; win_b = {}; win_z = {};
      m_fa = 0; m_fb = 0; m_fz = 0; m_primed = 0;
      m_count = 0; m_dir = 0; m_step = 0; m_err = 0;
    end else begin
      sa = sq_a.pop_front(); sq_a.push_back(qa);
      sb = sq_b.pop_front(); sq_b.push_back(qb);
      sz = sq_z.pop_front(); sq_z.push_back(qz);
      win_a.push_back(sa); if (win_a.size() > FL) void'(win_a.pop_front());
      win_b.push_back(sb); if (win_b.size() > FL) void'(win_b.pop_front());
      win_z.push_back(sz); if (win_z.size() > FL) void'(win_z.pop_front());
      na = full_of(win_a, !m_fa) ? !m_fa : m_fa;
      nb = full_of(win_b, !m_fb) ? !m_fb : m_fb;
      nz = full_of(win_z, !m_fz) ? !m_fz : m_fz;
      chg = (na != m_fa) || (nb != m_fb);
      up = 0; dn = 0; m_err = 0;
      if (!m_primed) begin
        if (chg || (full_of(win_a, 1'b0) && full_of(win_b, 1'b0))) m_primed = 1;
      end else if (chg) begin
        d = (pos_of[{na, nb}] - pos_of[{m_fa, m_fb}] + 4) % 4;
        up = (d == 1); dn = (d == 3); m_err = (d == 2);
      end
      m_step = up | dn;
      if (up) m_dir = 1;
      if (dn) m_dir = 0;
`ifdef QDEC_INDEX_CLR_EN
      zrise = nz && !m_fz;
`else
      zrise = 0;
`endif
      if (load)       m_count = int'(data);
      else if (zrise) m_count = 0;
      else if (up)    m_count = (m_count + 1) % 65536;
      else if (dn)    m_count = (m_count + 65535) % 65536;
      m_fa = na; m_fb = nb; m_fz = nz;
    end
  endtask

  // One clock: update the model, let the DUT clock, compare on the falling edge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("data_out", 32'(data_out), 32'(m_count));
    chk("step", 32'(step), 32'(m_step));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("err", 32'(err), 32'(m_err));
    if (step) nsteps++;
    if (err) nerrs++;
  endtask

  initial begin
    logic [1:0] up_seq [4];
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    rst = 0; qa = 1; qb = 1; qz = 0; load = 0; data = '0;
    nsteps = 0; nerrs = 0;

    // Reset with A=B=1 held, then release and let it prime.
    repeat (3) cyc();
    chk("rst_count", 32'(data_out), 32'h0);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1; nsteps = 0; nerrs = 0;
    repeat (12) cyc();
    chk("prime_count", 32'(data_out), 32'h0);
    chk("prime_steps", 32'(nsteps), 32'h0);
    chk("prime_errs", 32'(nerrs), 32'h0);

    // Restart from 00 and walk one full up cycle, 8 cycles per level.
    rst = 0; qa = 0; qb = 0; cyc(); rst = 1;
    repeat (6) cyc();
    nsteps = 0; lat = 0;
    for (int s = 0; s < 4; s++) begin
      {qa, qb} = up_seq[s];
      for (int i = 1; i <= 8; i++) begin
        cyc();
        if (s == 0 && step && lat == 0) lat = i;
      end
    end
    chk("up_latency", 32'(lat), 32'd5);
    chk("up4_count", 32'(data_out), 32'd4);
    chk("up4_steps", 32'(nsteps), 32'd4);
    chk("up4_dir", 32'(dir), 32'd1);

    // Load 0, step down to wrap to all-ones, then back up to 0.
    load = 1; data = 16'h0000; cyc(); load = 0;
    qb = 1; repeat (8) cyc();
    chk("wrap_down", 32'(data_out), 32'h0000FFFF);
    chk("wrap_dir", 32'(dir), 32'd0);
    qb = 0; repeat (8) cyc();
    chk("wrap_up", 32'(data_out), 32'h0);

    // Two-cycle glitch on A is rejected; a 00->11 jump raises one err.
    nsteps = 0; nerrs = 0;
    qa = 1; repeat (2) cyc(); qa = 0; repeat (8) cyc();
    chk("glitch_count", 32'(data_out), 32'h0);
    chk("glitch_steps", 32'(nsteps), 32'h0);
    qa = 1; qb = 1; repeat (8) cyc();
    chk("jump_errs", 32'(nerrs), 32'd1);
    chk("jump_count", 32'(data_out), 32'h0);

    // Load on the same edge as a decoded up step (11 -> 01).
    qa = 0; repeat (4) cyc();
    load = 1; data = 16'h1234; cyc(); load = 0;
    chk("ldstep_count", 32'(data_out), 32'h1234);
    chk("ldstep_step", 32'(step), 32'd1);
    chk("ldstep_dir", 32'(dir), 32'd1);
    repeat (4) cyc();

    // Index pulse with count at 0x0010.
    load = 1; data = 16'h0010; cyc(); load = 0;
    qz = 1; repeat (4) cyc(); qz = 0; repeat (8) cyc();
`ifdef QDEC_INDEX_CLR_EN
    chk("index_clear", 32'(data_out), 32'h0);
`else
    chk("index_ignored", 32'(data_out), 32'h10);
`endif

    // Randomized walk: single steps, double jumps, glitches, loads, resets.
    for (int n = 0; n < 400; n++) begin
      int r, hold;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 0; cyc(); rst = 1;
      end else if (r < 75) begin
        if ($urandom_range(0, 1) == 1) qa = ~qa; else qb = ~qb;
      end else if (r < 85) begin
        qa = ~qa; qb = ~qb;
      end else begin
        qa = ~qa;
        repeat ($urandom_range(1, 2)) cyc();
        qa = ~qa;
      end
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        load = ($urandom_range(0, 19) == 0);
        data = WIDTH'($urandom);
        cyc();
      end
      load = 0;
    end
    repeat (10) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
